pattern_rom_sequencer: RTL
==========================

PATTERN_ROM_SEQUENCER -- requirements
Module: pattern_rom_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clock cycles between successive memory reads (legal: TICK_DIV >= RD_LAT+3).
REQ-002 SHALL have parameter DEPTH, default 16, number of bits read per run (legal: 1..16).
REQ-003 SHALL have parameter RD_LAT, default 1, block-memory read latency in cycles (legal: 1 or 2).
REQ-004 SHALL have port clock_100Mhz, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, level sampled in IDLE to begin a run.
REQ-007 SHALL have port pause, input, 1, freezes sequencing while high.
REQ-008 SHALL have port abort, input, 1, terminates a run immediately.
REQ-009 SHALL have port douta, input, 1, block-memory read data.
REQ-010 SHALL have port ena, output, 1, block-memory enable.
REQ-011 SHALL have port addra, output, 4, block-memory address.
REQ-012 SHALL have port bit_out, output, 1, last captured memory bit for the pattern detector.
REQ-013 SHALL have port bit_valid, output, 1, one-cycle strobe qualifying bit_out.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at end of a completed run.
REQ-016 SHALL have port bits_sent, output, 5, count of bit_valid pulses in the current or last run.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, EMIT, GAP, FINISH, all registered.
REQ-018 IDLE with start=1 -> ISSUE; addra<=0, bits_sent<=0, tick counter<=0.
REQ-019 ISSUE lasts one cycle with ena=1 and addra stable; ena SHALL be 0 in every other state.
REQ-020 WAIT lasts exactly RD_LAT cycles, then EMIT.
REQ-021 On entering EMIT, bit_out<=douta and bit_valid=1 for exactly that one cycle; bits_sent increments by 1 on the same edge.
REQ-022 EMIT -> FINISH if bits_sent (after increment) == DEPTH, else -> GAP.
REQ-023 Tick counter SHALL start at 0 in the ISSUE cycle and increment each non-paused cycle; GAP -> ISSUE with addra+1 when counter reaches TICK_DIV-1, counter reset to 0.
REQ-024 Consecutive ISSUE cycles and consecutive bit_valid pulses SHALL be exactly TICK_DIV cycles apart when pause stays 0.
REQ-025 First bit_valid SHALL occur RD_LAT+2 cycles after the edge sampling start (ISSUE at +1).
REQ-026 addra SHALL never exceed DEPTH-1; no wrap-around within a run.
REQ-027 FINISH lasts one cycle with done=1, then IDLE; bit_out and bits_sent hold until the next start.
REQ-028 pause=1 in GAP SHALL freeze state and tick counter; pause in ISSUE/WAIT/EMIT SHALL take effect only on reaching GAP (an issued read always completes).
REQ-029 start while busy SHALL be ignored; start held high through FINISH SHALL begin a new run one cycle after returning to IDLE.
REQ-030 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, ena=0, bit_valid=0, done=0, bits_sent held; abort has priority over pause and start.

Reset
REQ-031 reset=1 SHALL, at the next edge, force IDLE, ena=0, addra=0, bit_out=0, bit_valid=0, done=0, busy=0, bits_sent=0, tick counter=0, overriding all other inputs including mid-run.

Verification (TICK_DIV=8, DEPTH=16, RD_LAT=1, memory = 16'hA5C3 LSB at address 0)
REQ-032 start pulse at cycle 0 -> ISSUE addra=0 at cycle 1, bit_valid at cycle 3 with bit_out=1, 16 pulses 8 cycles apart, bits in address order, done at cycle 124, busy low from cycle 125.
REQ-033 pause high for 20 cycles during GAP after 4th bit -> 5th bit_valid delayed exactly 20 cycles, no extra ena pulses.
REQ-034 abort during WAIT of 6th read -> IDLE next cycle, no 6th bit_valid, bits_sent=5, done never pulses.
REQ-035 reset asserted during GAP after 10th bit -> all outputs at reset values next cycle; subsequent start re-reads from addra=0.
REQ-036 start held high continuously -> runs back-to-back, IDLE for exactly one cycle between done and next ISSUE; start pulses mid-run have no effect.
REQ-037 RD_LAT=2 rerun of REQ-032 -> first bit_valid at cycle 4, same bit sequence and 8-cycle spacing.

Source files
------------

// File: rtl/pattern_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_rom_sequencer
// Description : Walks a block memory one bit per TICK_DIV cycles and strobes
//               each captured bit to a downstream pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_rom_sequencer #(
    parameter int TICK_DIV = 100000000,
    parameter int DEPTH    = 16,
    parameter int RD_LAT   = 1
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic       douta,
    output logic       ena,
    output logic [3:0] addra,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       done,
    output logic [4:0] bits_sent
);

    localparam int                  c_CNT_W     = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0]  c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_TICK_ONE  = c_CNT_W'(1);
    localparam logic [4:0]          c_DEPTH     = 5'(DEPTH);
    localparam logic                c_LAT_LAST  = 1'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_EMIT   = 3'd3,
        S_GAP    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_tick;
    logic                r_lat;
    logic                r_ena;
    logic [3:0]          r_addra;
    logic                r_bit_out;
    logic                r_bit_valid;
    logic                r_busy;
    logic                r_done;
    logic [4:0]          r_bits_sent;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_lat       <= 1'b0;
            r_ena       <= 1'b0;
            r_addra     <= 4'd0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bits_sent <= 5'd0;
        end else begin
            r_ena       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state     <= S_ISSUE;
                            r_ena       <= 1'b1;
                            r_addra     <= 4'd0;
                            r_bits_sent <= 5'd0;
                            r_tick      <= '0;
                            r_busy      <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        r_state <= S_WAIT;
                        r_lat   <= 1'b0;
                        r_tick  <= r_tick + c_TICK_ONE;
                    end
                    S_WAIT: begin
                        r_tick <= r_tick + c_TICK_ONE;
                        if (r_lat == c_LAT_LAST) begin
                            r_state     <= S_EMIT;
                            r_bit_out   <= douta;
                            r_bit_valid <= 1'b1;
                            r_bits_sent <= r_bits_sent + 5'd1;
                        end else begin
                            r_lat <= r_lat + 1'b1;
                        end
                    end
                    S_EMIT: begin
                        r_tick <= r_tick + c_TICK_ONE;
                        if (r_bits_sent == c_DEPTH) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                    // Pause only freezes here so an issued read always lands.
                    S_GAP: begin
                        if (!pause) begin
                            if (r_tick == c_TICK_LAST) begin
                                r_state <= S_ISSUE;
                                r_ena   <= 1'b1;
                                r_addra <= r_addra + 4'd1;
                                r_tick  <= '0;
                            end else begin
                                r_tick <= r_tick + c_TICK_ONE;
                            end
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ena       = r_ena;
    assign addra     = r_addra;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bits_sent = r_bits_sent;

endmodule
`default_nettype wire
